// File: rtl/add_mop_csv_acc.sv
// Multi-operand carry-save accumulator with valid/ready result handshake.

package lau_pkg;
  typedef enum logic {SMALL, FAST} speed_t;
endpackage

module add_mop_csv_acc #(
  parameter int unsigned     width   = 8,
  parameter int unsigned     lanes   = 4,
  parameter int unsigned     owidth  = 16,
  parameter bit              sgn     = 1'b0,
  parameter bit              resolve = 1'b1,
  parameter int unsigned     cw      = 8,
  parameter lau_pkg::speed_t speed   = lau_pkg::FAST
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IV,
  output logic                   IR,
  input  logic                   ILAST,
  input  logic [lanes*width-1:0] A,
  output logic                   OV,
  input  logic                   OR,
  output logic [owidth-1:0]      S,
  output logic [owidth-1:0]      C,
  output logic [owidth-1:0]      Z,
  output logic [cw-1:0]          CNT
);

  localparam int unsigned nops = lanes + 2;

  typedef logic [owidth-1:0] vec_t;
  typedef enum logic [1:0] {IDLE, ACC, RES, HOLD} state_t;

  state_t state_q, state_n;
  logic   take;
  vec_t   ops [nops];
  vec_t   sum_n, car_n;

  // Lane extension to the accumulator width.
  function automatic vec_t ext(input logic [width-1:0] x);
    if (sgn) return owidth'($signed(x));
    else     return owidth'(x);
  endfunction

  // One 3:2 counter slice across the whole word; top carry is dropped.
  function automatic void csa(input vec_t a, input vec_t b, input vec_t d,
                              output vec_t so, output vec_t co);
    so = a ^ b ^ d;
    co = ((a & b) | (a & d) | (b & d)) << 1;
  endfunction

  // Compressor operands: extended lanes plus the running carry-save pair.
  always_comb begin
    for (int k = 0; k < int'(lanes); k++) ops[k] = ext(A[k*width +: width]);
    ops[lanes]   = (state_q == IDLE) ? '0 : S;
    ops[lanes+1] = (state_q == IDLE) ? '0 : C;
  end

  if (speed == lau_pkg::FAST) begin : g_tree
    // Wallace-style reduction: each level groups operands in threes.
    always_comb begin
      vec_t v [nops];
      vec_t t [nops];
      int   n;
      int   m;
      v = ops;
      n = int'(nops);
      for (int lvl = 0; lvl < int'(nops); lvl++) begin
        if (n > 2) begin
          m = 0;
          for (int i = 0; i < int'(nops); i++) t[i] = '0;
          for (int g = 0; g < int'(nops) / 3; g++) begin
            if (3*g + 2 < n) begin
              csa(v[3*g], v[3*g+1], v[3*g+2], t[m], t[m+1]);
              m = m + 2;
            end
          end
          for (int r = 0; r < int'(nops); r++) begin
            if (r >= 3*(n/3) && r < n) begin
              t[m] = v[r];
              m = m + 1;
            end
          end
          v = t;
          n = m;
        end
      end
      sum_n = v[0];
      car_n = v[1];
    end
  end else begin : g_chain
    // Linear carry-save chain: one 3:2 stage per remaining operand.
    always_comb begin
      vec_t ps;
      vec_t pc;
      vec_t ns;
      vec_t nc;
      ps = ops[0];
      pc = ops[1];
      for (int k = 2; k < int'(nops); k++) begin
        csa(ps, pc, ops[k], ns, nc);
        ps = ns;
        pc = nc;
      end
      sum_n = ps;
      car_n = pc;
    end
  end

  assign take = IV && IR;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE, ACC: begin
        if (take) begin
          if (ILAST) state_n = resolve ? RES : HOLD;
          else       state_n = ACC;
        end
      end
      RES:     state_n = HOLD;
      HOLD:    if (OR) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake flags and accumulator/result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      IR  <= 1'b1;
      OV  <= 1'b0;
      S   <= '0;
      C   <= '0;
      Z   <= '0;
      CNT <= '0;
    end else begin
      IR <= (state_n == IDLE) || (state_n == ACC);
      OV <= (state_n == HOLD);
      if (take) begin
        S <= sum_n;
        C <= car_n;
        if (CNT != '1) CNT <= CNT + cw'(1);
      end
      if (resolve && state_q == RES) Z <= S + C;
      if (state_q == HOLD && OR) begin
        S   <= '0;
        C   <= '0;
        Z   <= '0;
        CNT <= '0;
      end
    end
  end

endmodule

// File: tb/tb_add_mop_csv_acc.sv
// Directed bench: three accumulator instances (unsigned, signed, unresolved).

module tb_add_mop_csv_acc;

  localparam int unsigned W  = 8;
  localparam int unsigned L  = 4;
  localparam int unsigned OW = 16;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst   [3];
  logic            iv    [3];
  logic            ilast [3];
  logic            orr   [3];
  logic            ir    [3];
  logic            ov    [3];
  logic [L*W-1:0]  a     [3];
  logic [OW-1:0]   s     [3];
  logic [OW-1:0]   c     [3];
  logic [OW-1:0]   z     [3];
  logic [CW-1:0]   cnt   [3];

  int total = 0;
  int bad   = 0;

  add_mop_csv_acc #(.width(W), .lanes(L), .owidth(OW), .sgn(1'b0), .resolve(1'b1),
                    .cw(CW), .speed(lau_pkg::FAST)) u_plain (
    .CLK(clk), .RST(rst[0]), .IV(iv[0]), .IR(ir[0]), .ILAST(ilast[0]), .A(a[0]),
    .OV(ov[0]), .OR(orr[0]), .S(s[0]), .C(c[0]), .Z(z[0]), .CNT(cnt[0]));

  add_mop_csv_acc #(.width(W), .lanes(L), .owidth(OW), .sgn(1'b1), .resolve(1'b1),
                    .cw(CW), .speed(lau_pkg::FAST)) u_sgn (
    .CLK(clk), .RST(rst[1]), .IV(iv[1]), .IR(ir[1]), .ILAST(ilast[1]), .A(a[1]),
    .OV(ov[1]), .OR(orr[1]), .S(s[1]), .C(c[1]), .Z(z[1]), .CNT(cnt[1]));

  add_mop_csv_acc #(.width(W), .lanes(L), .owidth(OW), .sgn(1'b0), .resolve(1'b0),
                    .cw(CW), .speed(lau_pkg::SMALL)) u_nores (
    .CLK(clk), .RST(rst[2]), .IV(iv[2]), .IR(ir[2]), .ILAST(ilast[2]), .A(a[2]),
    .OV(ov[2]), .OR(orr[2]), .S(s[2]), .C(c[2]), .Z(z[2]), .CNT(cnt[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sc(input int d);
    logic [OW-1:0] t;
    t = s[d] + c[d];
    return 32'(t);
  endfunction

  // Present one beat at a negedge; returns at the negedge after it was taken.
  task automatic send(input int d, input logic [31:0] v, input logic last);
    int n;
    iv[d]    = 1'b1;
    a[d]     = v;
    ilast[d] = last;
    n = 0;
    while (!ir[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_ready", 32'(ir[d]), 32'd1);
    @(negedge clk);
    iv[d]    = 1'b0;
    ilast[d] = 1'b0;
    a[d]     = 32'hDEAD_BEEF;
  endtask

  // Count negedges until OV is seen (bounded).
  task automatic wait_ov(input int d, output int n);
    n = 0;
    while (!ov[d] && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [OW-1:0] hs, hc;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; iv[d] = 1'b0; ilast[d] = 1'b0; a[d] = '0; orr[d] = 1'b1;
    end
    @(negedge clk);
    chk("rst_ov",  32'(ov[0]),  32'd0);
    chk("rst_ir",  32'(ir[0]),  32'd1);
    chk("rst_s",   32'(s[0]),   32'd0);
    chk("rst_c",   32'(c[0]),   32'd0);
    chk("rst_z",   32'(z[0]),   32'd0);
    chk("rst_cnt", 32'(cnt[0]), 32'd0);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    @(negedge clk);

    // Basic two-beat sum
    send(0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0);
    send(0, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b1);
    chk("basic_ir_res", 32'(ir[0]), 32'd0);
    chk("basic_ov_res", 32'(ov[0]), 32'd0);
    wait_ov(0, n);
    chk("basic_lat",   32'(n),      32'd1);
    chk("basic_z",     32'(z[0]),   32'd36);
    chk("basic_sc",    sc(0),       32'd36);
    chk("basic_cnt",   32'(cnt[0]), 32'd2);
    chk("basic_ir_hold", 32'(ir[0]), 32'd0);
    chk("basic_c0",    32'(c[0][0]), 32'd0);
    @(negedge clk);
    chk("basic_ov_drop", 32'(ov[0]),  32'd0);
    chk("basic_ir_idle", 32'(ir[0]),  32'd1);
    chk("basic_cnt_clr", 32'(cnt[0]), 32'd0);

    // Signed single beat
    send(1, 32'hFFFF_FFFF, 1'b1);
    wait_ov(1, n);
    chk("sgn_lat", 32'(n),      32'd1);
    chk("sgn_z",   32'(z[1]),   32'h0000_FFFC);
    chk("sgn_cnt", 32'(cnt[1]), 32'd1);
    @(negedge clk);

    // Wrap past 2^owidth
    for (int i = 0; i < 65; i++) send(0, 32'hFFFF_FFFF, i == 64);
    wait_ov(0, n);
    chk("wrap_z",   32'(z[0]),   32'd764);
    chk("wrap_sc",  sc(0),       32'd764);
    chk("wrap_cnt", 32'(cnt[0]), 32'd65);
    @(negedge clk);

    // Beat counter saturation
    for (int i = 0; i < 300; i++) send(0, 32'h0000_0001, i == 299);
    wait_ov(0, n);
    chk("sat_z",   32'(z[0]),   32'd300);
    chk("sat_cnt", 32'(cnt[0]), 32'd255);
    @(negedge clk);

    // Backpressure with ignored IV pulses
    orr[0] = 1'b0;
    send(0, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1);
    wait_ov(0, n);
    chk("bp_z0", 32'(z[0]), 32'd10);
    hs = s[0];
    hc = c[0];
    for (int i = 0; i < 5; i++) begin
      iv[0] = 1'b1; ilast[0] = 1'b1; a[0] = $urandom;
      @(negedge clk);
      chk("bp_ov",  32'(ov[0]),  32'd1);
      chk("bp_ir",  32'(ir[0]),  32'd0);
      chk("bp_z",   32'(z[0]),   32'd10);
      chk("bp_cnt", 32'(cnt[0]), 32'd1);
      chk("bp_s",   32'(s[0]),   32'(hs));
      chk("bp_c",   32'(c[0]),   32'(hc));
    end
    iv[0] = 1'b0; ilast[0] = 1'b0;
    orr[0] = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(ov[0]), 32'd0);
    send(0, {8'd1, 8'd1, 8'd1, 8'd1}, 1'b1);
    wait_ov(0, n);
    chk("bp_next_z",   32'(z[0]),   32'd4);
    chk("bp_next_cnt", 32'(cnt[0]), 32'd1);
    @(negedge clk);

    // Reset mid-packet
    for (int i = 0; i < 3; i++) send(0, {8'd9, 8'd9, 8'd9, 8'd9}, 1'b0);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("mid_ov",  32'(ov[0]),  32'd0);
    chk("mid_cnt", 32'(cnt[0]), 32'd0);
    chk("mid_ir",  32'(ir[0]),  32'd1);
    send(0, {8'd0, 8'd0, 8'd0, 8'd2}, 1'b1);
    chk("mid_ov_res", 32'(ov[0]), 32'd0);
    wait_ov(0, n);
    chk("mid_z",   32'(z[0]),   32'd2);
    chk("mid_cnt1", 32'(cnt[0]), 32'd1);
    @(negedge clk);

    // resolve=0 with gaps between beats
    send(2, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0);
    repeat (2) @(negedge clk);
    send(2, {8'd40, 8'd30, 8'd20, 8'd10}, 1'b0);
    @(negedge clk);
    send(2, {8'd0, 8'd0, 8'd0, 8'd100}, 1'b1);
    wait_ov(2, n);
    chk("nr_lat", 32'(n),      32'd0);
    chk("nr_sc",  sc(2),       32'd210);
    chk("nr_z",   32'(z[2]),   32'd0);
    chk("nr_cnt", 32'(cnt[2]), 32'd3);
    chk("nr_ir",  32'(ir[2]),  32'd0);
    @(negedge clk);
    chk("nr_ov_drop", 32'(ov[2]), 32'd0);
    chk("nr_ir_idle", 32'(ir[2]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
